// File: rtl/cpu_feed_pkg.sv
// Shared CPU definitions: feed FSM encoding, instruction queue entry layout
// and injected-opcode/vector constants common to the feed stage and status unit.
package cpu_feed_pkg;

  localparam logic [1:0] F_IR   = 2'd0;
  localparam logic [1:0] F_K    = 2'd1;
  localparam logic [1:0] F_DROP = 2'd2;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] k;
    logic [15:0] pc;
  } feed_entry_t;

  localparam logic [15:0] VEC_RESET   = 16'h0000;
  localparam logic [15:0] VEC_INT     = 16'h0004;
  localparam logic [15:0] OP_INT_CALL = 16'h940e;  // long call opcode used for interrupt entry
  localparam logic [15:0] OP_NOP      = 16'h0000;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_feed_queue.sv
// Small FIFO of fetched {ir, k, pc} entries; power-of-two depth, registered storage,
// flush has priority over push/pop.
module feed_queue
  import cpu_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  feed_entry_t             push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output feed_entry_t             head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = 1;
  localparam logic [AW:0]   CntOne = 1;

  feed_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (pop && !push) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_feed.sv
// Instruction feed stage: fetches IR/K word pairs into a small queue and hands one
// instruction per cycle to decode, or the status unit's injected pair on replace_ir.
module cpu_feed
  import cpu_feed_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        hold_fetch,
  input  logic        hold_decode,
  input  logic        replace_ir,
  input  logic [15:0] int_ir,
  input  logic [15:0] int_k,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        feed_valid,
  output logic [15:0] feed_ir,
  output logic [15:0] feed_k,
  output logic [15:0] feed_pc,
  input  logic        feed_ready,
  output logic        feed_ack
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   ir_tmp_q, ir_tmp_d;
  logic [15:0]   pc_tmp_q, pc_tmp_d;
  logic          req_q, req_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  feed_entry_t   head, push_data;
  logic          push, pop, mem_done, queue_valid;

  assign mem_done    = req_q & mem_ack;
  assign queue_valid = (count != '0);
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;

  always_comb begin
    feed_valid = replace_ir | queue_valid;
    feed_ir    = replace_ir ? int_ir : head.ir;
    feed_k     = replace_ir ? int_k  : head.k;
    feed_pc    = (replace_ir && !queue_valid) ? pc_q : head.pc;
  end

  assign feed_ack  = feed_valid & feed_ready & ~hold_decode & ~rst;
  assign pop       = feed_ack & ~replace_ir & ~redirect;
  assign push      = mem_done & (state_q == F_K) & ~redirect;
  assign push_data = '{ir: ir_tmp_q, k: mem_rdata, pc: pc_tmp_q};

  // Occupancy once this cycle's push/pop land; decides a back-to-back IR fetch.
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q;
    ir_tmp_d = ir_tmp_q;
    pc_tmp_d = pc_tmp_q;
    if (redirect) begin
      pc_d = redirect_pc;
      // An unacked request cannot be retracted; its data is discarded in F_DROP.
      req_d   = req_q & ~mem_ack;
      state_d = (req_q && !mem_ack) ? F_DROP : F_IR;
    end else begin
      case (state_q)
        F_IR: begin
          if (mem_done) begin
            ir_tmp_d = mem_rdata;
            pc_tmp_d = pc_q;
            pc_d     = pc_inc(pc_q);
            addr_d   = pc_inc(pc_q);
            state_d  = F_K;
          end else if (!req_q && !hold_fetch && (count < DepthCnt)) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
        F_K: begin
          if (mem_done) begin
            pc_d    = pc_inc(pc_q);
            state_d = F_IR;
            if (!hold_fetch && (count_after < DepthCnt)) begin
              addr_d = pc_inc(pc_q);
            end else begin
              req_d = 1'b0;
            end
          end
        end
        F_DROP: begin
          if (mem_done) begin
            req_d   = 1'b0;
            state_d = F_IR;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = F_IR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= F_IR;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      ir_tmp_q <= '0;
      pc_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      ir_tmp_q <= ir_tmp_d;
      pc_tmp_q <= pc_tmp_d;
    end
  end

  feed_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_cpu_feed.sv
// Scoreboard bench for cpu_feed: expected reads and handoffs are queued by the
// stimulus and consumed by a monitor whenever the DUT completes a read or a handoff.
module tb_cpu_feed;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        hold_fetch, hold_decode, replace_ir, redirect, feed_ready;
  logic [15:0] int_ir, int_k, redirect_pc;
  logic        feed_valid, feed_ack;
  logic [15:0] feed_ir, feed_k, feed_pc;

  always #5 clk = ~clk;

  cpu_feed #(
    .DEPTH   (2),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hold_fetch (hold_fetch),
    .hold_decode(hold_decode),
    .replace_ir (replace_ir),
    .int_ir     (int_ir),
    .int_k      (int_k),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .feed_valid (feed_valid),
    .feed_ir    (feed_ir),
    .feed_k     (feed_k),
    .feed_pc    (feed_pc),
    .feed_ready (feed_ready),
    .feed_ack   (feed_ack)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] k;
    logic [15:0] pc;
    bit          chk_pc;
  } exp_t;

  exp_t        exp_feed[$];
  logic [15:0] exp_addr[$];
  int checks    = 0;
  int errors    = 0;
  int ack_cnt   = 0;
  int read_cnt  = 0;
  int ack_delay = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push_feed(input logic [15:0] ir, input logic [15:0] k, input logic [15:0] pc,
                           input bit chk_pc);
    exp_t e;
    e.ir = ir;
    e.k = k;
    e.pc = pc;
    e.chk_pc = chk_pc;
    exp_feed.push_back(e);
  endtask

  task automatic push_reads(input logic [15:0] first, input int n);
    logic [15:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      a = a + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    int target;
    target = ack_cnt + n;
    for (int i = 0; i < budget && ack_cnt < target; i++) tick();
    check(name, ack_cnt, target);
  endtask

  task automatic wait_addr(input string name, input logic [15:0] a, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      found = mem_req && (mem_addr == a);
    end
    check(name, found, 1);
  endtask

  // Memory: acks after ack_delay idle cycles; read data equals the address.
  initial begin : mem_model
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        read_cnt++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr %0h, expected no read", mem_addr);
        end else begin
          check("read_addr", mem_addr, exp_addr.pop_front());
        end
      end
      if (feed_ack) begin
        ack_cnt++;
        if (exp_feed.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handoff: got ir %0h pc %0h, expected none", feed_ir, feed_pc);
        end else begin
          e = exp_feed.pop_front();
          check("handoff_ir", feed_ir, e.ir);
          check("handoff_k", feed_k, e.k);
          if (e.chk_pc) check("handoff_pc", feed_pc, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    feed_ready = 1'b0;
    hold_fetch = 1'b0;
    hold_decode = 1'b0;
    replace_ir = 1'b0;
    int_ir = '0;
    int_k = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_feed_valid", feed_valid, 0);
    check("rst_feed_ack", feed_ack, 0);
    replace_ir = 1'b1;
    int_ir = 16'h1111;
    feed_ready = 1'b1;
    #1;
    check("rst_inject_valid", feed_valid, 1);
    check("rst_inject_ack", feed_ack, 0);
    replace_ir = 1'b0;
    feed_ready = 1'b0;

    // Fill with decode stalled: exactly two pairs fit.
    push_reads(16'h0000, 4);
    tick();
    rst = 1'b0;
    n = 0;
    while (!feed_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_valid_latency", n, 3);
    check("first_ir", feed_ir, 16'h0000);
    check("first_k", feed_k, 16'h0001);
    check("first_pc", feed_pc, 16'h0000);
    idle(20);
    check("full_read_count", read_cnt, 4);
    check("full_mem_req", mem_req, 0);

    // One handoff frees a slot; fetch resumes at 0004.
    push_feed(16'h0000, 16'h0001, 16'h0000, 1'b1);
    push_reads(16'h0004, 2);
    feed_ready = 1'b1;
    wait_acks("one_ack", 1, 20);
    feed_ready = 1'b0;
    check("next_head_ir", feed_ir, 16'h0002);
    idle(20);
    check("resume_read_count", read_cnt, 6);
    check("resume_mem_req", mem_req, 0);

    // Injection with a non-empty queue does not pop.
    replace_ir = 1'b1;
    int_ir = 16'h1348;
    int_k = 16'hfffc;
    feed_ready = 1'b1;
    push_feed(16'h1348, 16'hfffc, 16'h0000, 1'b0);
    #1;
    check("inject_ir", feed_ir, 16'h1348);
    check("inject_k", feed_k, 16'hfffc);
    check("inject_ack", feed_ack, 1);
    tick();
    replace_ir = 1'b0;
    feed_ready = 1'b0;
    tick();
    check("inject_head_kept", feed_ir, 16'h0002);
    check("inject_no_refetch", mem_req, 0);

    // Redirect while the K read of 0010/0011 is outstanding with slow memory.
    ack_delay = 3;
    push_reads(16'h0010, 2);
    push_reads(16'h8000, 8);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    check("flush_valid", feed_valid, 0);
    replace_ir = 1'b1;
    #1;
    check("inject_empty_pc", feed_pc, 16'h0010);
    replace_ir = 1'b0;
    wait_addr("k_req_0011", 16'h0011, 40);
    redirect = 1'b1;
    redirect_pc = 16'h8000;
    tick();
    redirect = 1'b0;
    check("drop_queue_empty", feed_valid, 0);
    push_feed(16'h8000, 16'h8001, 16'h8000, 1'b1);
    push_feed(16'h8002, 16'h8003, 16'h8002, 1'b1);
    feed_ready = 1'b1;
    wait_acks("redirect_acks", 2, 200);
    feed_ready = 1'b0;
    idle(80);
    check("redirect_reads_done", exp_addr.size(), 0);
    check("redirect_head_pc", feed_pc, 16'h8004);

    // PC wrap: IR at FFFF, K from 0000.
    ack_delay = 0;
    push_reads(16'hffff, 6);
    redirect = 1'b1;
    redirect_pc = 16'hffff;
    tick();
    redirect = 1'b0;
    idle(20);
    check("wrap_ir", feed_ir, 16'hffff);
    check("wrap_k", feed_k, 16'h0000);
    check("wrap_pc", feed_pc, 16'hffff);
    push_feed(16'hffff, 16'h0000, 16'hffff, 1'b1);
    feed_ready = 1'b1;
    wait_acks("wrap_ack", 1, 20);
    feed_ready = 1'b0;
    idle(20);
    check("wrap_reads_done", exp_addr.size(), 0);
    check("wrap_next_pc", feed_pc, 16'h0001);

    // hold_fetch raised while the K read is outstanding.
    ack_delay = 2;
    push_reads(16'h0100, 2);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    wait_addr("k_req_0101", 16'h0101, 40);
    hold_fetch = 1'b1;
    idle(12);
    check("hold_mem_req", mem_req, 0);
    check("hold_pushed_valid", feed_valid, 1);
    check("hold_pushed_pc", feed_pc, 16'h0100);
    check("hold_reads_done", exp_addr.size(), 0);
    hold_decode = 1'b1;
    feed_ready = 1'b1;
    #1;
    check("hold_decode_ack", feed_ack, 0);
    tick();
    hold_decode = 1'b0;
    feed_ready = 1'b0;
    push_reads(16'h0102, 6);
    push_feed(16'h0100, 16'h0101, 16'h0100, 1'b1);
    push_feed(16'h0102, 16'h0103, 16'h0102, 1'b1);
    hold_fetch = 1'b0;
    feed_ready = 1'b1;
    wait_acks("release_acks", 2, 100);
    feed_ready = 1'b0;
    idle(80);
    check("final_reads_done", exp_addr.size(), 0);
    check("final_handoffs_done", exp_feed.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
